riscv_sw_debounce: RTL and testbench
====================================

RISCV_SW_DEBOUNCE -- requirements
Module: riscv_sw_debounce

Interface
REQ-001 The block SHALL have parameter SAMPLE_DIV, default 100000, meaning clock cycles per debounce sample tick (1 ms at 100 MHz); legal range 2 or more.
REQ-002 The block SHALL have parameter STABLE_CNT, default 4, meaning consecutive differing samples required to accept a new switch level; legal range 1 to 15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port sw_raw, input, 24 bits: raw board switch pins, asynchronous to clk.
REQ-006 The block SHALL have port sw, output, 24 bits: debounced switch levels, to be fed to the IO bridge sw input that is read at 0xfffffc00.
REQ-007 The block SHALL have port sw_valid, output, 1 bit: high once the first full debounce window after reset has completed.
REQ-008 The block SHALL have port sw_changed, output, 1 bit: sticky flag set when any sw bit changes.
REQ-009 The block SHALL have port sw_changed_clr, input, 1 bit: a one-cycle pulse that clears sw_changed.

Function
REQ-010 The block SHALL pass sw_raw through a 2-flop synchronizer per bit (sync1, then sync2); only sync2 is used downstream.
REQ-011 The prescaler SHALL count 0 to SAMPLE_DIV-1 and then wrap to 0; tick SHALL be high for exactly one cycle when count equals SAMPLE_DIV-1.
REQ-012 Prescaler width SHALL be $clog2(SAMPLE_DIV); per-bit counter width SHALL be $clog2(STABLE_CNT+1); no counter SHALL overflow.
REQ-013 Each bit SHALL have its own stable counter cnt[i], updated only on tick cycles.
REQ-014 On a tick with sync2[i] equal to sw[i], cnt[i] SHALL be set to 0.
REQ-015 On a tick with sync2[i] not equal to sw[i] and cnt[i] less than STABLE_CNT-1, cnt[i] SHALL be incremented.
REQ-016 On a tick with sync2[i] not equal to sw[i] and cnt[i] equal to STABLE_CNT-1, sw[i] SHALL take the value of sync2[i] and cnt[i] SHALL be set to 0.
REQ-017 A glitch shorter than STABLE_CNT consecutive ticks SHALL never change sw.
REQ-018 Latency from a stable sw_raw change to the sw update SHALL be at most 2 + STABLE_CNT*SAMPLE_DIV cycles.
REQ-019 Bits SHALL be independent; multiple bits MAY update on the same tick.
REQ-020 An init counter SHALL count ticks from reset; sw_valid SHALL rise on the STABLE_CNT-th tick and then stay high until reset.
REQ-021 sw SHALL still update before sw_valid is high.
REQ-022 sw_changed SHALL be set in the cycle after any sw bit changes.
REQ-023 sw_changed SHALL be cleared in the cycle after sw_changed_clr is high.
REQ-024 When a set and sw_changed_clr occur in the same cycle, the set SHALL win and sw_changed SHALL stay 1.

Reset
REQ-025 Asserting rst SHALL immediately (asynchronously) force sync1, sync2, sw, all cnt, the prescaler, the init counter, sw_valid and sw_changed to 0.
REQ-026 Reset asserted in the middle of a debounce window SHALL discard the partial count; counting restarts from 0 after rst is released.

Configuration
REQ-027 With the macro RISCV_SW_CHANGE_FLAG_EN defined, the block SHALL implement sw_changed per REQ-022 to REQ-024.
REQ-028 Without RISCV_SW_CHANGE_FLAG_EN, sw_changed SHALL be tied to constant 0, sw_changed_clr SHALL be ignored, and no flag register SHALL exist.

Verification (bench parameters: SAMPLE_DIV=4, STABLE_CNT=3)
REQ-029 Scenario "after reset": release rst with sw_raw=0 -> sw=0, sw_changed=0, sw_valid rises exactly 12 cycles after reset release.
REQ-030 Scenario "stable change": set sw_raw=24'h00A5C3 and hold -> sw=24'h00A5C3 within 14 cycles; sw_changed=1 (macro on).
REQ-031 Scenario "glitch": pulse sw_raw[0]=1 for 8 cycles, then return it to 0 -> sw[0] stays 0 and sw_changed stays 0.
REQ-032 Scenario "simultaneous set and clear": pulse sw_changed_clr in the same cycle sw changes -> sw_changed=1; pulse clr again with no change -> sw_changed=0 the next cycle.
REQ-033 Scenario "reset mid-window": set sw_raw=24'hFFFFFF, assert rst after 6 cycles, release it -> sw=0 immediately; sw=24'hFFFFFF no earlier than 12 cycles after release.
REQ-034 Scenario "macro off": rerun the stable-change scenario with RISCV_SW_CHANGE_FLAG_EN undefined -> sw updates as before, sw_changed is constant 0.

Source files
------------

// File: rtl/riscv_sw_debounce.sv
// riscv_sw_debounce
//   Debounces 24 board switches for the IO bridge switch register (0xfffffc00).
//   Each raw pin goes through a two-flop synchronizer. A free-running prescaler
//   makes a one-cycle sample tick. A new level is accepted once STABLE_CNT
//   consecutive ticks have sampled a value that differs from the current level.
//
// Parameters
//   SAMPLE_DIV  clock cycles per sample tick (>= 2)
//   STABLE_CNT  consecutive differing samples needed to accept a level (1..15)
//
// Ports
//   clk             system clock, rising edge
//   rst             asynchronous, active-high reset
//   sw_raw[23:0]    raw switch pins, asynchronous to clk
//   sw[23:0]        debounced switch levels
//   sw_valid        high once the first full debounce window after reset is done
//   sw_changed      sticky flag, set when any sw bit changes
//   sw_changed_clr  one-cycle pulse that clears sw_changed
//
// Configuration
//   RISCV_SW_CHANGE_FLAG_EN  when defined, sw_changed is a real sticky flag;
//                            otherwise sw_changed is 0 and sw_changed_clr is ignored.

module riscv_sw_debounce #(
  parameter int SAMPLE_DIV = 100000,
  parameter int STABLE_CNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] sw_raw,
  output logic [23:0] sw,
  output logic        sw_valid,
  output logic        sw_changed,
  input  logic        sw_changed_clr
);

  localparam int PW = $clog2(SAMPLE_DIV);
  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);

  logic [23:0]         sync1;
  logic [23:0]         sync2;
  logic [PW-1:0]       pre;
  logic                tick;
  logic [23:0][CW-1:0] cnt;
  logic [23:0][CW-1:0] cnt_nxt;
  logic [23:0]         sw_nxt;
  logic [CW-1:0]       init_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  assign tick = (pre == PRE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PRE_ONE;
    end
  end

  // Per-bit stable counters: any sample that agrees with the current level
  // restarts the run, so only an unbroken run of differing samples wins.
  always_comb begin
    sw_nxt  = sw;
    cnt_nxt = cnt;
    if (tick) begin
      for (int i = 0; i < 24; i++) begin
        if (sync2[i] == sw[i]) begin
          cnt_nxt[i] = '0;
        end else if (cnt[i] == CNT_LAST) begin
          sw_nxt[i]  = sync2[i];
          cnt_nxt[i] = '0;
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw  <= '0;
      cnt <= '0;
    end else begin
      sw  <= sw_nxt;
      cnt <= cnt_nxt;
    end
  end

  // The init counter stops once sw_valid is set, so it never exceeds
  // STABLE_CNT-1 and cannot wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_cnt <= '0;
      sw_valid <= 1'b0;
    end else if (tick && !sw_valid) begin
      if (init_cnt == CNT_LAST) begin
        sw_valid <= 1'b1;
      end else begin
        init_cnt <= init_cnt + CNT_ONE;
      end
    end
  end

`ifdef RISCV_SW_CHANGE_FLAG_EN
  logic changed_flag;

  // A change in the same cycle as a clear takes priority so no event is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      changed_flag <= 1'b0;
    end else if (sw_nxt != sw) begin
      changed_flag <= 1'b1;
    end else if (sw_changed_clr) begin
      changed_flag <= 1'b0;
    end
  end

  assign sw_changed = changed_flag;
`else
  logic unused_clr;

  assign unused_clr = sw_changed_clr;
  assign sw_changed = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_sw_debounce.sv
module tb_riscv_sw_debounce;
  localparam int DIV = 4;
  localparam int SC  = 3;
`ifdef RISCV_SW_CHANGE_FLAG_EN
  localparam logic FLAG_EN = 1'b1;
`else
  localparam logic FLAG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] sw_raw;
  logic        sw_changed_clr;
  logic [23:0] sw;
  logic        sw_valid;
  logic        sw_changed;

  always #5 clk = ~clk;

  riscv_sw_debounce #(.SAMPLE_DIV(DIV), .STABLE_CNT(SC)) dut (
    .clk(clk),
    .rst(rst),
    .sw_raw(sw_raw),
    .sw(sw),
    .sw_valid(sw_valid),
    .sw_changed(sw_changed),
    .sw_changed_clr(sw_changed_clr)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [23:0] sw;
    logic        valid;
    logic        chg;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: edges counted since reset release, a tick on every
  // DIV-th edge, the synchronizer seen as a two-edge delay line, and a bit
  // accepted when the last SC tick samples since its previous acceptance
  // all differ from its current level.
  int          m_cyc;
  logic [23:0] m_level;
  logic        m_flag;
  logic [23:0] m_raw_hist[$];
  logic [23:0] m_tick_hist[$];
  int          m_acc[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cyc   = 0;
    m_level = '0;
    m_flag  = 1'b0;
    m_raw_hist.delete();
    m_tick_hist.delete();
    exp_q.delete();
    for (int i = 0; i < 24; i++) m_acc[i] = 0;
  endtask

  task automatic model_step();
    logic [23:0] samp;
    logic        flip;
    logic        all_diff;
    int          t;
    m_cyc++;
    samp = (m_raw_hist.size() >= 2) ? m_raw_hist[0] : 24'h0;
    m_raw_hist.push_back(sw_raw);
    if (m_raw_hist.size() > 2) void'(m_raw_hist.pop_front());
    flip = 1'b0;
    if (m_cyc % DIV == 0) begin
      m_tick_hist.push_back(samp);
      t = m_tick_hist.size();
      for (int i = 0; i < 24; i++) begin
        if (t - m_acc[i] >= SC) begin
          all_diff = 1'b1;
          for (int k = t - SC; k < t; k++)
            if (m_tick_hist[k][i] == m_level[i]) all_diff = 1'b0;
          if (all_diff) begin
            m_level[i] = ~m_level[i];
            m_acc[i]   = t;
            flip       = 1'b1;
          end
        end
      end
    end
    if (FLAG_EN) begin
      if (flip) m_flag = 1'b1;
      else if (sw_changed_clr) m_flag = 1'b0;
    end
    exp_q.push_back({m_level, (m_tick_hist.size() >= SC), m_flag});
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Monitor: the DUT presents sw/sw_valid/sw_changed every cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        check("reset_sw", sw, 0);
        check("reset_valid", sw_valid, 0);
        check("reset_changed", sw_changed, 0);
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_sw", sw, e.sw);
        check("sb_valid", sw_valid, e.valid);
        check("sb_changed", sw_changed, e.chg);
      end
    end
  end

  initial begin
    int n;
    rst            = 1'b1;
    sw_raw         = '0;
    sw_changed_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    n = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (sw_valid) begin
        n = k;
        break;
      end
    end
    check("valid_rise_cycle", n, 12);
    check("after_reset_sw", sw, 0);
    check("after_reset_changed", sw_changed, 0);

    @(negedge clk);
    sw_raw[0] = 1'b1;
    repeat (8) @(negedge clk);
    sw_raw[0] = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_sw0", sw[0], 0);
    check("glitch_changed", sw_changed, 0);

    sw_raw = 24'h00A5C3;
    n = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (sw == 24'h00A5C3) begin
        n = k;
        break;
      end
    end
    check("stable_latency_le14", (n > 0 && n <= 14), 1);
    check("stable_changed", sw_changed, FLAG_EN);

    @(negedge clk);
    sw_changed_clr = 1'b1;
    @(negedge clk);
    sw_changed_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("clr_clears", sw_changed, 0);

    // Clear is pulsed before every tick edge until sw[5] flips, so the last
    // pulse lands on the very edge that updates sw.
    sw_raw = sw_raw ^ 24'h000020;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      sw_changed_clr = ((m_cyc + 1) % DIV == 0);
      @(posedge clk);
      #1;
      if (sw[5] == 1'b1) begin
        n = k;
        break;
      end
    end
    check("simul_sw5_updated", (n > 0), 1);
    check("simul_set_wins", sw_changed, FLAG_EN);
    @(negedge clk);
    sw_changed_clr = 1'b1;
    @(posedge clk);
    #1;
    check("clr_no_change", sw_changed, 0);
    @(negedge clk);
    sw_changed_clr = 1'b0;

    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 2) == 0)
        sw_raw = sw_raw ^ (24'h1 << $urandom_range(0, 23));
      else
        sw_raw = 24'($urandom);
      repeat ($urandom_range(1, 20)) begin
        sw_changed_clr = ($urandom_range(0, 7) == 0);
        @(negedge clk);
      end
    end
    sw_changed_clr = 1'b0;

    sw_raw = 24'h00A5C3;
    repeat (20) @(negedge clk);
    check("pre_reset_sw", sw, 24'h00A5C3);
    sw_raw = 24'hFFFFFF;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_async_sw", sw, 0);
    check("rst_async_valid", sw_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (sw == 24'hFFFFFF) begin
        n = k;
        break;
      end
    end
    check("rst_mid_window_ge12", (n >= 12 && n <= 14), 1);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
